// File: rtl/cpu_pkg.sv
// Shared CPU types: 32-bit word, bubble instruction, fetch FSM states and PC select codes.
package cpu_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DISCARD = 2'd1,
    ST_HOLD    = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_KEEP   = 2'd0,
    PC_INC    = 2'd1,
    PC_TARGET = 2'd2,
    PC_SAVED  = 2'd3
  } pc_sel_t;

endpackage

// File: rtl/if_pc_unit.sv
// Program counter with +4 adder, next-PC mux and the redirect target saved while a stale fetch drains.
module if_pc_unit
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic    clk,
  input  logic    rst_n,
  input  pc_sel_t sel,
  input  logic    save_target,
  input  word_t   target,
  output word_t   pc,
  output word_t   pc_plus4_c
);

  word_t saved_target;

  assign pc_plus4_c = pc + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      saved_target <= '0;
    end else begin
      case (sel)
        PC_INC:    pc <= pc_plus4_c;
        PC_TARGET: pc <= target;
        PC_SAVED:  pc <= saved_target;
        default:   pc <= pc;
      endcase
      if (save_target) saved_target <= target;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch stage and IF/ID pipeline register.
// Define IF_SKID_BUFFER_EN to park a response that arrives during a hold instead of refetching it.
module if_id_stage
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC  = 32'h0000_0000,
  parameter word_t NOP_INSTR = NOP_WORD
) (
  input  logic  CLK,
  input  logic  RESET,
  input  logic  INSTR_BUSY_WAIT,
  input  word_t INSTR_READDATA,
  output logic  INSTR_READ,
  output word_t INSTR_ADDR,
  input  logic  DATA_BUSY_WAIT,
  input  logic  STALL,
  input  logic  BRANCH_TAKEN,
  input  word_t BRANCH_TARGET,
  output word_t INSTRUCTION_OUT,
  output word_t PC_OUT,
  output word_t PC_INCREMENT4_OUT,
  output logic  VALID_OUT
);

  fetch_state_t state, state_nxt;
  pc_sel_t      pc_sel;
  logic         save_target, ifid_load, ifid_flush, skid_load, skid_clear;
  logic         hold, branch, resp;
  word_t        pc, pc_plus4, target_word, skid_instr, skid_pc, src_instr, src_pc;

  assign hold        = STALL | DATA_BUSY_WAIT;
  // EX holds BRANCH_TAKEN through a data freeze, so act on it only once the freeze lifts.
  assign branch      = BRANCH_TAKEN & ~DATA_BUSY_WAIT;
  assign resp        = ~INSTR_BUSY_WAIT;
  assign target_word = BRANCH_TARGET & 32'hFFFF_FFFC;
  assign INSTR_READ  = RESET & (state != ST_HOLD);
  assign INSTR_ADDR  = pc;
  assign src_instr   = (state == ST_HOLD) ? skid_instr : INSTR_READDATA;
  assign src_pc      = (state == ST_HOLD) ? skid_pc : pc;

  if_pc_unit #(.RESET_PC(RESET_PC)) u_pc (
    .clk        (CLK),
    .rst_n      (RESET),
    .sel        (pc_sel),
    .save_target(save_target),
    .target     (target_word),
    .pc         (pc),
    .pc_plus4_c (pc_plus4)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) state <= ST_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pc_sel      = PC_KEEP;
    save_target = 1'b0;
    ifid_load   = 1'b0;
    ifid_flush  = 1'b0;
    skid_load   = 1'b0;
    skid_clear  = 1'b0;
    case (state)
      ST_FETCH: begin
        if (branch) begin
          ifid_flush = 1'b1;
          skid_clear = 1'b1;
          if (resp) begin
            pc_sel = PC_TARGET;
          end else begin
            save_target = 1'b1;
            state_nxt   = ST_DISCARD;
          end
        end else if (resp) begin
          if (!hold) begin
            ifid_load = 1'b1;
            pc_sel    = PC_INC;
          end
`ifdef IF_SKID_BUFFER_EN
          else begin
            skid_load = 1'b1;
            state_nxt = ST_HOLD;
          end
`endif
        end
      end
      // The outstanding read belongs to the old path; its data is dropped.
      ST_DISCARD: begin
        if (branch) begin
          ifid_flush = 1'b1;
          skid_clear = 1'b1;
          if (resp) begin
            pc_sel    = PC_TARGET;
            state_nxt = ST_FETCH;
          end else begin
            save_target = 1'b1;
          end
        end else if (resp) begin
          pc_sel    = PC_SAVED;
          state_nxt = ST_FETCH;
        end
      end
`ifdef IF_SKID_BUFFER_EN
      ST_HOLD: begin
        if (branch) begin
          ifid_flush = 1'b1;
          skid_clear = 1'b1;
          pc_sel     = PC_TARGET;
          state_nxt  = ST_FETCH;
        end else if (!hold) begin
          ifid_load = 1'b1;
          pc_sel    = PC_INC;
          state_nxt = ST_FETCH;
        end
      end
`endif
      default: state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET || skid_clear) begin
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (skid_load) begin
      skid_instr <= INSTR_READDATA;
      skid_pc    <= pc;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET || ifid_flush) begin
      INSTRUCTION_OUT   <= NOP_INSTR;
      PC_OUT            <= '0;
      PC_INCREMENT4_OUT <= '0;
      VALID_OUT         <= 1'b0;
    end else if (ifid_load) begin
      INSTRUCTION_OUT   <= src_instr;
      PC_OUT            <= src_pc;
      PC_INCREMENT4_OUT <= pc_plus4;
      VALID_OUT         <= 1'b1;
    end
  end

endmodule
